// File: rtl/mac_acc_stage.sv
// ---------------------------------------------------------------------------
// mac_acc_stage
//
// Purpose:
//   Accumulates a burst of unsigned 8-bit products into an ACC_W-bit sum.
//   A burst is requested with start and len. The block then accepts len
//   terms over a valid/ready handshake on p. It presents the sum on acc_out
//   with acc_valid until the consumer takes it with acc_ready.
//
// Configuration:
//   MAC_SAT_EN  - when defined, overflowing additions clamp the accumulator
//                 to 2^ACC_W-1. When undefined (default), they wrap modulo
//                 2^ACC_W. Either way, a carry out sets the sticky ovf flag.
//
// Parameters:
//   ACC_W  - accumulator / result width (>= 9)
//   LEN_W  - width of the term-count input
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request a new burst (honoured only in IDLE)
//   len        in   number of terms in the burst, sampled with start
//   p          in   unsigned product term
//   p_valid    in   p holds a valid term
//   p_ready    out  block accepts p this cycle (ACC state)
//   acc_out    out  registered burst result
//   acc_valid  out  acc_out is valid (DONE state)
//   acc_ready  in   consumer takes acc_out
//   busy       out  block is not IDLE
//   ovf        out  sticky overflow flag for the current burst
// ---------------------------------------------------------------------------
module mac_acc_stage #(
    parameter int ACC_W = 10,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       p,
    input  logic             p_valid,
    output logic             p_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               take;
    logic [ACC_W:0]     sum_w;

    // Add with one extra bit so the carry out of ACC_W bits is visible.
    function automatic logic [ACC_W-1:0] acc_next(input logic [ACC_W:0] s);
`ifdef MAC_SAT_EN
        // Once clamped, every later term carries out again, so the sum stays clamped.
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
        return s[ACC_W-1:0];
`endif
    endfunction

    assign take  = (state_q == ACC) && p_valid;
    assign sum_w = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, p};

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (p_valid && (cnt_q == LEN_W'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // start is deliberately not looked at here; a new burst needs an IDLE cycle.
                if (acc_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        p_ready   = 1'b0;
        acc_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ACC: begin
                p_ready = 1'b1;
                busy    = 1'b1;
            end
            DONE: begin
                acc_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if ((state_q == IDLE) && start) begin
            acc_d = '0;
            cnt_d = len;
            ovf_d = 1'b0;
        end else if (take) begin
            acc_d = acc_next(sum_w);
            cnt_d = cnt_q - LEN_W'(1);
            if (sum_w[ACC_W]) begin
                ovf_d = 1'b1;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_out = acc_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_mac_acc_stage.sv
module tb_mac_acc_stage;

    localparam int ACC_W = 10;
    localparam int LEN_W = 4;

`ifdef MAC_SAT_EN
    localparam logic [ACC_W-1:0] OVF_RESULT = 10'd1023;
`else
    localparam logic [ACC_W-1:0] OVF_RESULT = 10'd101;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [7:0]       p;
    logic             p_valid;
    logic             p_ready;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic             busy;
    logic             ovf;

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;

    mac_acc_stage #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .p         (p),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .acc_out   (acc_out),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every cycle a result is presented it must match the
    // head of the queue; the entry retires on the handshake.
    always @(negedge clk) begin
        if (rst_n && acc_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(acc_out), 32'hFFFF_FFFF);
            end else begin
                check("acc_out", 32'(acc_out), 32'(exp_q[0].acc));
                check("ovf", 32'(ovf), 32'(exp_q[0].ovf));
                if (acc_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; p = '0; p_valid = 1'b0; acc_ready = 1'b0;
        #12;
        // Reset state
        check("rst_p_ready", 32'(p_ready), 0);
        check("rst_acc_valid", 32'(acc_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_acc_out", 32'(acc_out), 0);
        check("rst_ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        tick();
        check("idle_after_rst", 32'(busy), 0);

        // Three terms of 225 -> 675, one cycle after the last handshake
        exp_q.push_back('{acc: 10'd675, ovf: 1'b0});
        start = 1'b1; len = 4'd3;
        tick();
        start = 1'b0;
        check("acc_p_ready", 32'(p_ready), 1);
        check("acc_busy", 32'(busy), 1);
        p = 8'd225; p_valid = 1'b1;
        tick();
        tick();
        check("not_done_early", 32'(acc_valid), 0);
        tick();
        p_valid = 1'b0;
        check("done_latency", 32'(acc_valid), 1);
        check("done_p_ready", 32'(p_ready), 0);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        check("back_idle_1", 32'(busy), 0);

        // Five terms of 225 overflow: wrap to 101 or clamp to 1023
        exp_q.push_back('{acc: OVF_RESULT, ovf: 1'b1});
        start = 1'b1; len = 4'd5;
        tick();
        start = 1'b0;
        p = 8'd225; p_valid = 1'b1;
        repeat (5) tick();
        p_valid = 1'b0;
        check("ovf_done", 32'(acc_valid), 1);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;

        // Gapped input, result held while the consumer stalls
        exp_q.push_back('{acc: 10'd30, ovf: 1'b0});
        start = 1'b1; len = 4'd2;
        tick();
        start = 1'b0;
        check("ovf_cleared", 32'(ovf), 0);
        p = 8'd10; p_valid = 1'b1;
        tick();
        p_valid = 1'b0; p = 8'd99;
        tick();
        tick();
        check("gap_still_acc", 32'(p_ready), 1);
        p = 8'd20; p_valid = 1'b1;
        tick();
        p_valid = 1'b0;
        repeat (4) tick();
        check("held_valid", 32'(acc_valid), 1);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        check("back_idle_3", 32'(busy), 0);

        // len = 0 goes straight to DONE with zero
        exp_q.push_back('{acc: 10'd0, ovf: 1'b0});
        start = 1'b1; len = 4'd0;
        tick();
        start = 1'b0;
        check("len0_done", 32'(acc_valid), 1);
        check("len0_p_ready", 32'(p_ready), 0);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;

        // Reset mid-burst discards the partial sum
        start = 1'b1; len = 4'd4;
        tick();
        start = 1'b0;
        p = 8'd50; p_valid = 1'b1;
        tick();
        tick();
        p_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_acc_out", 32'(acc_out), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_p_ready", 32'(p_ready), 0);
        check("abort_acc_valid", 32'(acc_valid), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_stays_idle", 32'(busy), 0);
        exp_q.push_back('{acc: 10'd7, ovf: 1'b0});
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0;
        p = 8'd7; p_valid = 1'b1;
        tick();
        p_valid = 1'b0;
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;

        // start coincident with acc_ready in DONE is ignored
        exp_q.push_back('{acc: 10'd3, ovf: 1'b0});
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0;
        p = 8'd3; p_valid = 1'b1;
        tick();
        p_valid = 1'b0;
        start = 1'b1; len = 4'd2; acc_ready = 1'b1;
        tick();
        start = 1'b0; acc_ready = 1'b0;
        check("ignored_start_busy", 32'(busy), 0);
        check("ignored_start_p_ready", 32'(p_ready), 0);
        tick();
        check("ignored_start_idle", 32'(busy), 0);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mac_acc_stage.md
MAC_ACC_STAGE -- requirements
Module: mac_acc_stage

Interface
REQ-001 The block SHALL have parameter ACC_W, default 10, giving the accumulator and result width in bits (ACC_W >= 9).
REQ-002 The block SHALL have parameter LEN_W, default 4, giving the width of the term-count input.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: requests a new dot-product burst.
REQ-006 The block SHALL have port len, input, LEN_W bits: the number of product terms in the burst, sampled with start.
REQ-007 The block SHALL have port p, input, 8 bits: the unsigned 4x4 product from the upstream carry-save multiplier.
REQ-008 The block SHALL have port p_valid, input, 1 bit: p holds a valid term.
REQ-009 The block SHALL have port p_ready, output, 1 bit: the block accepts p this cycle.
REQ-010 The block SHALL have port acc_out, output, ACC_W bits: the burst result.
REQ-011 The block SHALL have port acc_valid, output, 1 bit: acc_out is valid.
REQ-012 The block SHALL have port acc_ready, input, 1 bit: the consumer takes acc_out.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 The block SHALL have port ovf, output, 1 bit: sticky overflow flag for the current burst.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-016 In IDLE, on start=1 the block SHALL clear the accumulator and ovf, load the counter with len, and go to ACC; if len=0 it SHALL go directly to DONE with acc_out=0.
REQ-017 In ACC, p_ready SHALL be 1, and p_ready SHALL be 0 in IDLE and DONE.
REQ-018 A term SHALL be accepted only on a cycle with p_valid=1 and p_ready=1: acc <= acc + zero-extended p and counter <= counter-1.
REQ-019 Cycles with p_valid=0 in ACC SHALL leave the accumulator and counter unchanged.
REQ-020 On acceptance of the last term (counter=1) the block SHALL go to DONE, and acc_valid SHALL assert on the next cycle, giving one cycle of latency from the last handshake.
REQ-021 In DONE, acc_valid SHALL be 1, acc_out and ovf SHALL be held stable, and the block SHALL return to IDLE on the cycle acc_ready=1.
REQ-022 start SHALL be ignored in ACC and DONE, including in the DONE cycle where acc_ready=1, so a new burst begins no earlier than the following IDLE cycle.
REQ-023 If an addition carries out of ACC_W bits, ovf SHALL be set and SHALL remain set until the next accepted start or reset.
REQ-024 acc_out SHALL be driven from a register, with no combinational path from p to acc_out.

Reset
REQ-025 While rst_n=0, and asynchronously on its assertion, the block SHALL force state=IDLE, acc=0, counter=0, ovf=0, p_ready=0, acc_valid=0 and busy=0.
REQ-026 Reset during ACC or DONE SHALL abort the burst and discard any partial sum.
REQ-027 After reset the block SHALL leave IDLE only on the first rising clk edge with rst_n=1 and start=1.

Configuration
REQ-028 Without macro MAC_SAT_EN, overflowing additions SHALL wrap modulo 2^ACC_W and set ovf.
REQ-029 With MAC_SAT_EN defined, overflowing additions SHALL clamp the accumulator to 2^ACC_W-1 and set ovf, and further terms in that burst SHALL keep it clamped.

Verification
REQ-030 start, len=3, then p=225 accepted three times (ACC_W=10) -> acc_valid one cycle after the third handshake, acc_out=675, ovf=0.
REQ-031 start, len=5, p=225 five times -> acc_out=101 with ovf=1 without MAC_SAT_EN; acc_out=1023 with ovf=1 with MAC_SAT_EN.
REQ-032 start, len=2, p_valid toggled 1,0,0,1 with p=10 then 20, and acc_ready held 0 for 4 cycles -> acc_out=30 held stable with acc_valid=1 throughout, then IDLE the cycle after acc_ready=1.
REQ-033 start, len=0 -> DONE in one cycle with acc_out=0, p_ready never asserted.
REQ-034 start, len=4, two terms accepted, then rst_n pulsed low mid-cycle -> all outputs 0 immediately; new burst with len=1, p=7 gives acc_out=7.
REQ-035 start asserted in DONE coincident with acc_ready=1 -> start ignored, block in IDLE, busy=0.
